// File: rtl/apb_req_master.sv
// apb_req_master
//   Converts a valid/ready command stream into APB setup/access transfers and
//   returns exactly one response pulse per accepted command (read data or an
//   error flag). Only one transfer is in flight at a time.
//
//   Ports
//     pclk, preset            clock, synchronous active-high reset
//     cmd_valid/cmd_ready     command handshake; cmd_write/cmd_addr/cmd_wdata payload
//     rsp_valid/rsp_rdata/rsp_err   one-cycle response, no backpressure
//     paddr/pwdata/pwrite/psel/penable   APB requester outputs (all registered)
//     prdata/pready/pslverr   APB completer inputs
//
//   RDATA_LATE=1 adds a CAPTURE cycle so completers that register prdata on
//   the completing edge are sampled one edge later.
//   TIMEOUT_CYCLES bounds the number of ACCESS cycles with pready low
//   (0 disables the bound).
module apb_req_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RDATA_LATE     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam bit LATE      = (RDATA_LATE != 0);
  localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam int TW        = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  // Timer value seen in the last permitted wait cycle; abort happens there.
  localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          err_q, err_nxt;   // pslverr held across CAPTURE
  rsp_t          rsp_nxt;
  logic          accept;

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_nxt   = err_q;
    rsp_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          timer_nxt = '0;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (pwrite || !LATE) begin
            state_nxt     = IDLE;
            rsp_nxt.vld   = 1'b1;
            rsp_nxt.err   = pslverr;
            rsp_nxt.rdata = (!pwrite && !pslverr) ? prdata : '0;
          end else begin
            state_nxt = CAPTURE;
            err_nxt   = pslverr;
          end
        end else if (TO_EN && (timer == TO_LAST)) begin
          state_nxt   = IDLE;
          rsp_nxt.vld = 1'b1;
          rsp_nxt.err = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      CAPTURE: begin
        state_nxt     = IDLE;
        rsp_nxt.vld   = 1'b1;
        rsp_nxt.err   = err_q;
        rsp_nxt.rdata = err_q ? '0 : prdata;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a flop driven from the next-state decode so that the APB
  // strobes and cmd_ready are glitch-free.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      timer     <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      err_q     <= err_nxt;
      cmd_ready <= (state_nxt == IDLE);
      psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable   <= (state_nxt == ACCESS);
      if (accept) begin
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
        pwrite <= cmd_write;
      end
      rsp_valid <= rsp_nxt.vld;
      rsp_err   <= rsp_nxt.err;
      rsp_rdata <= rsp_nxt.rdata;
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  always #5 pclk = ~pclk;

  apb_req_master #(.ADDR_W(32), .DATA_W(32), .RDATA_LATE(1), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // 5-register completer: 0x0 cntrl, 0x4..0x10 reg1..reg4; prdata registered
  // on the completing edge; other addresses answer with pslverr and 0.
  logic [31:0] regs [5] = '{32'h0, 32'h5A5A_5555, 32'h0, 32'h0, 32'h0000_FFFF};
  int          wait_cfg = 0;
  int          wcnt = 0;
  bit          stuck = 0;
  logic        addr_ok;
  logic [2:0]  idx;

  assign addr_ok = (paddr <= 32'h10) && (paddr[1:0] == 2'b00);
  assign idx     = paddr[4:2];
  assign pready  = !stuck && (wcnt == 0);
  assign pslverr = psel && penable && !addr_ok;

  initial prdata = '0;
  always @(posedge pclk) begin
    if (psel && !penable) wcnt <= wait_cfg;
    else if (psel && penable && wcnt != 0) wcnt <= wcnt - 1;
    if (psel && penable && pready) begin
      if (!addr_ok) prdata <= '0;
      else if (pwrite) regs[idx] <= pwdata;
      else prdata <= regs[idx];
    end
  end

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    string       name;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Monitor: response scoreboard plus APB phase bookkeeping.
  int          acc_cnt = 0, last_acc = 0;
  int          gap = 0, last_gap = 0;
  bit          prev_psel = 0, stable_bad = 0;
  logic [31:0] setup_addr = '0, setup_wdata = '0;

  always @(negedge pclk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk({e.name, "_err"}, rsp_err, e.err);
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
    if (psel && !penable) begin
      setup_addr  = paddr;
      setup_wdata = pwdata;
      acc_cnt     = 0;
    end else if (psel && penable) begin
      acc_cnt++;
      last_acc = acc_cnt;
      if (paddr !== setup_addr || pwdata !== setup_wdata) stable_bad = 1;
    end
    if (psel && !prev_psel) last_gap = gap;
    gap       = psel ? 0 : gap + 1;
    prev_psel = psel;
  end

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       input string nm, input bit track = 1);
    int   n;
    exp_t ent;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      ent.err = e_err; ent.rdata = e_rd; ent.acc = cyc; ent.lat = lat; ent.name = nm;
      exp_q.push_back(ent);
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", exp_q.size(), 64'd0);
      exp_q.delete();
    end
    @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // 1: late-capture read of reg1
    issue(1'b0, 32'h4, 32'h0, 1'b0, 32'h5A5A_5555, 4, "t1_rd4");
    wait_idle();

    // 2: write then back-to-back read of the same register
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0, 3, "t2_wr8");
    issue(1'b0, 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF, 4, "t2_rd8");
    wait_idle();
    chk("t2_psel_gap", last_gap, 1);

    // 3: three wait states on a write, then read it back
    wait_cfg = 3;
    issue(1'b1, 32'hC, 32'h1234_5678, 1'b0, 32'h0, 6, "t3_wr_wait");
    wait_idle();
    chk("t3_access_len", last_acc, 4);
    chk("t3_stable", stable_bad, 0);
    chk("t3_setup_addr", setup_addr, 32'hC);
    chk("t3_setup_wdata", setup_wdata, 32'h1234_5678);
    wait_cfg = 0;
    issue(1'b0, 32'hC, 32'h0, 1'b0, 32'h1234_5678, 4, "t3_rdC");
    wait_idle();

    // 4: pready stuck low -> abort after 16 ACCESS cycles
    stuck = 1;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 18, "t4_timeout");
    wait_idle();
    chk("t4_access_len", last_acc, 16);
    stuck = 0;
    @(negedge pclk);
    chk("t4_idle_ready", cmd_ready, 1);
    chk("t4_idle_psel", psel, 0);

    // 5: out-of-range read -> pslverr
    issue(1'b0, 32'h14, 32'h0, 1'b1, 32'h0, 4, "t5_slverr");
    wait_idle();

    // 6: reset during ACCESS drops the transfer
    issue(1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 0, "t6_drop", 1'b0);
    @(negedge pclk);
    chk("t6_in_access", penable, 1);
    preset = 1'b1;
    @(negedge pclk);
    chk("t6_rst_psel", psel, 0);
    chk("t6_rst_penable", penable, 0);
    chk("t6_rst_paddr", paddr, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    preset = 1'b0;
    repeat (4) @(negedge pclk);
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_FFFF, 4, "t6_rd10");
    wait_idle();

    repeat (3) @(negedge pclk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
